// File: rtl/fpmul_arb_pkg.sv
// Shared constants and types for the two-requester FP multiplier arbiter.
// The requester ID travels through the tag FIFO so each result reaches its owner.
package fpmul_arb_pkg;

    localparam int MUL_LAT_DEF = 4;
    localparam int DEPTH_DEF   = MUL_LAT_DEF + 2;

    typedef logic [31:0] fp_word_t;
    typedef logic        req_id_t;

    localparam req_id_t REQ_ID0 = 1'b0;
    localparam req_id_t REQ_ID1 = 1'b1;

endpackage

// File: rtl/fpmul_tag_fifo.sv
// Requester-ID FIFO tracking operations in flight inside the FP multiplier.
// Pointers wrap modulo DEPTH; a push into a full FIFO is accepted only alongside a pop.
module fpmul_tag_fifo
    import fpmul_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          push_i,
    input  req_id_t       push_id_i,
    input  logic          pop_i,
    output req_id_t       head_id_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return ptr + {{(PW-1){1'b0}}, 1'b1};
        end
    endfunction

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign head_id_o = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpmul_arb.sv
// Round-robin arbiter sharing one fixed-latency FP multiplier between two requesters.
// Results return in issue order and are steered back by a tag FIFO of requester IDs.
module fpmul_arb
    import fpmul_arb_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DEPTH   = MUL_LAT + 2
) (
    input  logic     CLK,
    input  logic     RST_n,
    input  logic     REQ0_VALID,
    input  logic     REQ1_VALID,
    output logic     REQ0_READY,
    output logic     REQ1_READY,
    input  fp_word_t REQ0_A,
    input  fp_word_t REQ0_B,
    input  fp_word_t REQ1_A,
    input  fp_word_t REQ1_B,
    output logic     MUL_VIN,
    output fp_word_t MUL_A,
    output fp_word_t MUL_B,
    input  logic     MUL_VOUT,
    input  fp_word_t MUL_Z,
    output logic     RSP0_VALID,
    output logic     RSP1_VALID,
    output fp_word_t RSP_Z,
    output logic     BUSY,
    output logic     ERR
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          gnt0_s, gnt1_s, grant_s, can_accept_s, pop_s;
    logic          fifo_full_s, fifo_empty_s;
    req_id_t       grant_id_s, head_id_s;
    logic [CW-1:0] count_s;

    req_id_t  last_grant_q, last_grant_d;
    logic     mul_vin_q, mul_vin_d;
    fp_word_t mul_a_q, mul_a_d;
    fp_word_t mul_b_q, mul_b_d;
    logic     rsp0_q, rsp0_d;
    logic     rsp1_q, rsp1_d;
    fp_word_t rsp_z_q, rsp_z_d;
    logic     err_q, err_d;

    // A full FIFO can still accept when the multiplier retires a result this cycle
    assign can_accept_s = !fifo_full_s || MUL_VOUT;

    // Round-robin grant; a tie goes to the requester not granted last
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (can_accept_s && REQ0_VALID && REQ1_VALID) begin
            if (last_grant_q == REQ_ID1) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (can_accept_s && REQ0_VALID) begin
            gnt0_s = 1'b1;
        end else if (can_accept_s && REQ1_VALID) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign REQ0_READY = gnt0_s;
    assign REQ1_READY = gnt1_s;
    assign grant_s    = gnt0_s | gnt1_s;
    assign grant_id_s = gnt1_s ? REQ_ID1 : REQ_ID0;
    assign pop_s      = MUL_VOUT && !fifo_empty_s;

    fpmul_tag_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_tag_fifo (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .push_i    (grant_s),
        .push_id_i (grant_id_s),
        .pop_i     (pop_s),
        .head_id_o (head_id_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .count_o   (count_s)
    );

    // Issue, response and error next-state
    always_comb begin
        last_grant_d = last_grant_q;
        mul_vin_d    = grant_s;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        if (grant_s) begin
            last_grant_d = grant_id_s;
            mul_a_d      = gnt1_s ? REQ1_A : REQ0_A;
            mul_b_d      = gnt1_s ? REQ1_B : REQ0_B;
        end else begin
            last_grant_d = last_grant_q;
        end
        rsp0_d = pop_s && (head_id_s == REQ_ID0);
        rsp1_d = pop_s && (head_id_s == REQ_ID1);
        if (pop_s) begin
            rsp_z_d = MUL_Z;
        end else begin
            rsp_z_d = rsp_z_q;
        end
        // A result with nothing outstanding is a protocol violation; it is dropped
        err_d = err_q | (MUL_VOUT & fifo_empty_s);
    end

    // Output and arbitration state registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            last_grant_q <= REQ_ID1;
            mul_vin_q    <= 1'b0;
            mul_a_q      <= 32'h0000_0000;
            mul_b_q      <= 32'h0000_0000;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rsp_z_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            mul_vin_q    <= mul_vin_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            rsp_z_q      <= rsp_z_d;
            err_q        <= err_d;
        end
    end

    assign MUL_VIN    = mul_vin_q;
    assign MUL_A      = mul_a_q;
    assign MUL_B      = mul_b_q;
    assign RSP0_VALID = rsp0_q;
    assign RSP1_VALID = rsp1_q;
    assign RSP_Z      = rsp_z_q;
    assign BUSY       = (count_s != {CW{1'b0}});
    assign ERR        = err_q;

endmodule
